traffic_phase_scheduler: RTL and testbench
==========================================

// Module: traffic_phase_scheduler
// PURPOSE
//  Timed phase sequencer for the highway/farm intersection. Drives both light heads through
//  green/yellow/all-red phases with 1 s ticks from an internal prescaler.
//  Enforces a minimum highway green and latches farm-sensor and pedestrian requests.
//  Sits between the sensor/button inputs and the light drivers; replaces ad-hoc delay flags with one timer.
// PARAMETERS
//  TICK_DIV      50_000_000  clk cycles per 1 s tick (>=2)
//  HWY_MIN_GREEN 10          minimum highway green, ticks (>=1)
//  FARM_GREEN    10          farm green duration, ticks (>=1)
//  YELLOW_T      3           yellow duration (both roads), ticks (>=1)
//  ALLRED_T      1           all-red clearance, ticks (>=1)
//  CNT_W         8           phase timer width; every *_T / *_GREEN value < 2**CNT_W
// PORTS
//  clk            in   1  system clock
//  rst            in   1  synchronous, active-high reset
//  sensor         in   1  farm-road vehicle present (level, may pulse 1 cycle)
//  ped_req        in   1  pedestrian crossing request (1-cycle pulse or level)
//  Highway_Light  out  3  {red,yellow,green}: 001 green, 010 yellow, 100 red
//  Farm_Light     out  3  same encoding
//  ped_walk       out  1  walk lamp; high only in FG
//  phase          out  3  current state encoding, for debug/monitoring
// BEHAVIOUR
//  Reset: state=HG, prescaler=0, timer=0, req=0 -> Highway_Light=001, Farm_Light=100, ped_walk=0, phase=HG.
//    Reset is applied in the next cycle from any state, including mid-phase; it discards pending requests.
//  Prescaler: counts 0..TICK_DIV-1 and wraps; tick=1 for the one cycle where count==TICK_DIV-1.
//  Timer: cleared to 0 on every state change; otherwise +1 on tick; saturates at HWY_MIN_GREEN-1 in HG.
//  Outputs: Moore decode of the state register (no extra latency); they change in the cycle the state changes.
//  req latch: set when sensor|ped_req. Cleared in the cycle FG is entered, unless sensor|ped_req is high in
//    that same cycle (set wins).
//  States (in order) and exits; each exit is evaluated only on a tick and takes effect on the next clk:
//    HG  hwy 001 / farm 100 : -> HY when timer==HWY_MIN_GREEN-1 && (req|sensor|ped_req); else stay
//    HY  hwy 010 / farm 100 : -> AR1 when timer==YELLOW_T-1
//    AR1 hwy 100 / farm 100 : -> FG  when timer==ALLRED_T-1
//    FG  hwy 100 / farm 001 : -> FY  when timer==FARM_GREEN-1; ped_walk=1
//    FY  hwy 100 / farm 010 : -> AR2 when timer==YELLOW_T-1
//    AR2 hwy 100 / farm 100 : -> HG  when timer==ALLRED_T-1
//  Phase durations: every phase except HG lasts exactly T*TICK_DIV cycles. State changes only on tick
//    boundaries, so the prescaler is never reset by a state change.
//  Late request: if HG has already served its minimum green, a request moves to HY on the next tick.
//  Unused encodings (6,7): go to HG on the next clk; outputs 100/100, ped_walk=0.
//  No legal state drives green or yellow on both roads at once.
// STRUCTURE
//  traffic_pkg: state localparams (HG=0,HY=1,AR1=2,FG=3,FY=4,AR2=5) and light codes (GREEN=3'b001,
//    YELLOW=3'b010, RED=3'b100).
//  Sub-module tick_prescaler (params TICK_DIV; ports clk, rst, tick) is instantiated once.
//  Top level holds the state register, timer, req latch and output decode.
// TESTING  (TICK_DIV=4, HWY_MIN_GREEN=5, FARM_GREEN=4, YELLOW_T=2, ALLRED_T=1; cycle 0 = first cycle rst=0)
//  1 rst held 3 cycles, then idle 100 cycles -> HG throughout; lights 001/100; ped_walk=0; ticks at 3,7,11...
//  2 sensor=1 only at cycle 3 -> HY@20, AR1@28, FG@32 (ped_walk=1), FY@48, AR2@56, HG@60;
//      never green/yellow on both roads.
//  3 No request until sensor pulse at cycle 60 (min green served) -> HY@64.
//  4 ped_req pulse during FG, from case 2 -> back in HG@60, then HY exactly 5 ticks later @80, with no sensor.
//  5 Sensor and FG entry in the same cycle (sensor high @32) -> req stays 1 after entry; next HG exits at min green.
//  6 rst=1 for one cycle mid-FY -> next cycle HG, 001/100, timer=0, req=0; no HY without a new request.

Source files
------------

// File: rtl/traffic_phase_scheduler_pkg.sv
// Shared state encoding, light codes and the state-to-lights decode for the intersection sequencer.
package traffic_phase_scheduler_pkg;

    typedef enum logic [2:0] {
        HG  = 3'd0,
        HY  = 3'd1,
        AR1 = 3'd2,
        FG  = 3'd3,
        FY  = 3'd4,
        AR2 = 3'd5
    } state_t;

    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] RED    = 3'b100;

    typedef struct packed {
        logic [2:0] hwy;
        logic [2:0] farm;
        logic       walk;
    } lights_t;

    // Unused encodings fall to all-red so a corrupted state never shows a go aspect.
    function automatic lights_t decode_lights(input state_t st);
        lights_t l;
        case (st)
            HG:      l = '{hwy: GREEN,  farm: RED,    walk: 1'b0};
            HY:      l = '{hwy: YELLOW, farm: RED,    walk: 1'b0};
            AR1:     l = '{hwy: RED,    farm: RED,    walk: 1'b0};
            FG:      l = '{hwy: RED,    farm: GREEN,  walk: 1'b1};
            FY:      l = '{hwy: RED,    farm: YELLOW, walk: 1'b0};
            AR2:     l = '{hwy: RED,    farm: RED,    walk: 1'b0};
            default: l = '{hwy: RED,    farm: RED,    walk: 1'b0};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_phase_scheduler_if.sv
// Sensor/button inputs and light-driver outputs of the phase sequencer.
interface traffic_phase_scheduler_if;
    logic       sensor;
    logic       ped_req;
    logic [2:0] Highway_Light;
    logic [2:0] Farm_Light;
    logic       ped_walk;
    logic [2:0] phase;

    modport master (
        output sensor, ped_req,
        input  Highway_Light, Farm_Light, ped_walk, phase
    );

    modport slave (
        input  sensor, ped_req,
        output Highway_Light, Farm_Light, ped_walk, phase
    );
endinterface

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_count;

    assign tick = (r_count == LAST);

    // Count 0..TICK_DIV-1 and wrap; state changes never restart it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end
endmodule

// File: rtl/traffic_phase_scheduler.sv
// Highway/farm phase sequencer: one phase timer on a 1 s tick, minimum highway green, latched requests.
module traffic_phase_scheduler
    import traffic_phase_scheduler_pkg::*;
#(
    parameter int unsigned TICK_DIV      = 50_000_000,
    parameter int unsigned HWY_MIN_GREEN = 10,
    parameter int unsigned FARM_GREEN    = 10,
    parameter int unsigned YELLOW_T      = 3,
    parameter int unsigned ALLRED_T      = 1,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    traffic_phase_scheduler_if.slave   bus
);
    localparam logic [CNT_W-1:0] HG_LAST = CNT_W'(HWY_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] FG_LAST = CNT_W'(FARM_GREEN - 1);
    localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] AR_LAST = CNT_W'(ALLRED_T - 1);

    logic             w_tick;
    logic             w_any_req;
    state_t           w_next;
    state_t           r_state;
    logic [CNT_W-1:0] r_timer;
    logic             r_req;
    lights_t          r_lights;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    assign w_any_req = bus.sensor | bus.ped_req;

    // Next phase: timed exits only on a tick; illegal encodings recover to HG immediately.
    always_comb begin
        w_next = r_state;
        case (r_state)
            HG:      w_next = (w_tick && (r_timer == HG_LAST) && (r_req || w_any_req)) ? HY : HG;
            HY:      w_next = (w_tick && (r_timer == Y_LAST))  ? AR1 : HY;
            AR1:     w_next = (w_tick && (r_timer == AR_LAST)) ? FG  : AR1;
            FG:      w_next = (w_tick && (r_timer == FG_LAST)) ? FY  : FG;
            FY:      w_next = (w_tick && (r_timer == Y_LAST))  ? AR2 : FY;
            AR2:     w_next = (w_tick && (r_timer == AR_LAST)) ? HG  : AR2;
            default: w_next = HG;
        endcase
    end

    // State, timer, request latch and lights all registered together so outputs track the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= HG;
            r_timer  <= '0;
            r_req    <= 1'b0;
            r_lights <= decode_lights(HG);
        end else begin
            r_state  <= w_next;
            r_lights <= decode_lights(w_next);
            // HG timer holds at its last value so a late request exits on the next tick.
            if (w_next != r_state) begin
                r_timer <= '0;
            end else if (w_tick && !((r_state == HG) && (r_timer == HG_LAST))) begin
                r_timer <= r_timer + CNT_W'(1);
            end else begin
                r_timer <= r_timer;
            end
            if (w_any_req) begin
                r_req <= 1'b1;
            end else if ((w_next == FG) && (r_state != FG)) begin
                r_req <= 1'b0;
            end else begin
                r_req <= r_req;
            end
        end
    end

    assign bus.Highway_Light = r_lights.hwy;
    assign bus.Farm_Light    = r_lights.farm;
    assign bus.ped_walk      = r_lights.walk;
    assign bus.phase         = r_state;
endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench: driver runs a phase/tick-count reference model and queues expected lights; monitor compares.
module tb_traffic_phase_scheduler;
    localparam int TD   = 4;
    localparam int MING = 5;
    localparam int FGT  = 4;
    localparam int YT   = 2;
    localparam int ART  = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    traffic_phase_scheduler_if bus_if ();

    traffic_phase_scheduler #(
        .TICK_DIV      (TD),
        .HWY_MIN_GREEN (MING),
        .FARM_GREEN    (FGT),
        .YELLOW_T      (YT),
        .ALLRED_T      (ART),
        .CNT_W         (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] hwy;
        logic [2:0] farm;
        logic       walk;
        logic [2:0] ph;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: phase index 0..5 (HG,HY,AR1,FG,FY,AR2), prescaler phase, ticks spent in phase.
    int         m_phase = 0;
    int         m_pres  = 0;
    int         m_ticks = 0;
    bit         m_req   = 1'b0;
    int         dur [6]      = '{MING, YT, ART, FGT, YT, ART};
    logic [2:0] hwy_tab [6]  = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
    logic [2:0] farm_tab [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};

    task automatic model_step(input bit s, input bit p, input bit r);
        int   nxt;
        bit   tick;
        bit   any;
        exp_t e;
        if (r) begin
            m_phase = 0;
            m_pres  = 0;
            m_ticks = 0;
            m_req   = 1'b0;
        end else begin
            tick   = (m_pres == TD - 1);
            m_pres = tick ? 0 : m_pres + 1;
            any    = s | p;
            nxt    = m_phase;
            if (tick) begin
                if (m_phase == 0) begin
                    if ((m_ticks + 1 >= MING) && (m_req || any)) nxt = 1;
                end else if (m_ticks + 1 >= dur[m_phase]) begin
                    nxt = (m_phase + 1) % 6;
                end
            end
            if (any) m_req = 1'b1;
            else if (nxt == 3 && m_phase != 3) m_req = 1'b0;
            if (nxt != m_phase) m_ticks = 0;
            else if (tick) m_ticks++;
            m_phase = nxt;
        end
        e.hwy  = hwy_tab[m_phase];
        e.farm = farm_tab[m_phase];
        e.walk = (m_phase == 3);
        e.ph   = 3'(m_phase);
        exp_q.push_back(e);
    endtask

    // Drive one cycle's inputs on the falling edge; expectation is for the state after the next rising edge.
    task automatic step(input bit s, input bit p, input bit r);
        bus_if.sensor  = s;
        bus_if.ped_req = p;
        rst            = r;
        model_step(s, p, r);
        @(negedge clk);
    endtask

    exp_t got;
    exp_t want;

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = {bus_if.Highway_Light, bus_if.Farm_Light, bus_if.ped_walk, bus_if.phase};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL outputs @%0t: got hwy=%b farm=%b walk=%b phase=%0d, expected hwy=%b farm=%b walk=%b phase=%0d",
                         $time, got.hwy, got.farm, got.walk, got.ph, want.hwy, want.farm, want.walk, want.ph);
            end
            total++;
            if (bus_if.Highway_Light != 3'b100 && bus_if.Farm_Light != 3'b100) begin
                bad++;
                $display("FAIL conflict @%0t: got hwy=%b farm=%b, expected at least one road red",
                         $time, bus_if.Highway_Light, bus_if.Farm_Light);
            end
        end
    end

    bit hold;

    initial begin
        bus_if.sensor  = 1'b0;
        bus_if.ped_req = 1'b0;
        @(negedge clk);
        // Reset then idle: HG throughout.
        repeat (3) step(1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 101; c++) step(1'b0, 1'b0, 1'b0);
        // One sensor pulse at cycle 3: full cycle back to HG.
        step(1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 70; c++) step(c == 3, 1'b0, 1'b0);
        // Late request after min green served.
        step(1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 70; c++) step(c == 60, 1'b0, 1'b0);
        // Pedestrian request during FG carries into the next HG.
        step(1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 90; c++) step(c == 3, c == 40, 1'b0);
        // Sensor high in the first FG cycle.
        step(1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 120; c++) step(c == 3 || c == 32, 1'b0, 1'b0);
        // Reset mid-FY discards the pending request.
        step(1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 120; c++) step(c == 3 || c == 50, 1'b0, c == 52);
        // Random pulses, held levels and occasional resets.
        hold = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 99) == 0) hold = ~hold;
            step(hold | ($urandom_range(0, 29) == 0), $urandom_range(0, 39) == 0,
                 $urandom_range(0, 599) == 0);
        end
        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
